// File: rtl/iob_rst_seq.sv
// Reset sequencer: filters N_SRC ready sources and releases N_OUT reset domains
// in index order with programmable spacing. Counts source drops and flags slow start-up.
module iob_rst_seq #(
  parameter int N_SRC       = 3,
  parameter int N_OUT       = 3,
  parameter int STABLE_CYC  = 16,
  parameter int STEP_CYC    = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int FAULT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_SRC-1:0]   src_i,
  input  logic               sw_rst_i,
  output logic [N_OUT-1:0]   rst_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [FAULT_W-1:0] fault_cnt_o,
  output logic [1:0]         state_o
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int PW = $clog2(STEP_CYC + 1);
  localparam int GW = $clog2(N_OUT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SW-1:0]      STABLE_LAST = SW'(STABLE_CYC - 1);
  localparam logic [PW-1:0]      STEP_LAST   = PW'(STEP_CYC - 1);
  localparam logic [GW-1:0]      STAGE_END   = GW'(N_OUT);
  localparam logic [TW-1:0]      TMO_MAX     = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]      TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [FAULT_W-1:0] FAULT_MAX   = {FAULT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_REL    = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   sync1_q, sync2_q;
  logic [SW-1:0]      stable_cnt_q, stable_cnt_d;
  logic [PW-1:0]      step_cnt_q, step_cnt_d;
  logic [GW-1:0]      stage_q, stage_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [N_OUT-1:0]   rst_q, rst_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [FAULT_W-1:0] fault_q, fault_d;

  logic src_ok_s, in_pre_s, drop_s, abort_s, rel_start_s, step_hit_s, tmo_hit_s;

  // stage_q is the index of the next domain to release; STAGE_END means all are out
  assign src_ok_s    = &sync2_q;
  assign in_pre_s    = (state_q == ST_WAIT) || (state_q == ST_STABLE);
  assign drop_s      = ((state_q == ST_REL) || (state_q == ST_RUN)) && !src_ok_s;
  assign abort_s     = drop_s || sw_rst_i;
  assign rel_start_s = (state_q == ST_STABLE) && src_ok_s && !sw_rst_i && (stable_cnt_q == STABLE_LAST);
  assign step_hit_s  = (state_q == ST_REL) && !abort_s && (step_cnt_q == STEP_LAST);
  assign tmo_hit_s   = in_pre_s && (tmo_cnt_q == TMO_LAST);

  // State register, counters, synchronisers and output flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_WAIT;
      sync1_q      <= {N_SRC{1'b0}};
      sync2_q      <= {N_SRC{1'b0}};
      stable_cnt_q <= {SW{1'b0}};
      step_cnt_q   <= {PW{1'b0}};
      stage_q      <= {GW{1'b0}};
      tmo_cnt_q    <= {TW{1'b0}};
      rst_q        <= {N_OUT{1'b1}};
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fault_q      <= {FAULT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      sync1_q      <= src_i;
      sync2_q      <= sync1_q;
      stable_cnt_q <= stable_cnt_d;
      step_cnt_q   <= step_cnt_d;
      stage_q      <= stage_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rst_q        <= rst_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state and sequencing counters
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    step_cnt_d   = step_cnt_q;
    stage_d      = stage_q;
    tmo_cnt_d    = tmo_cnt_q;
    if (rel_start_s) begin
      tmo_cnt_d = {TW{1'b0}};
    end else if (in_pre_s && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (abort_s) begin
      state_d      = ST_WAIT;
      stable_cnt_d = {SW{1'b0}};
      step_cnt_d   = {PW{1'b0}};
      stage_d      = {GW{1'b0}};
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (src_ok_s) begin
            state_d      = ST_STABLE;
            stable_cnt_d = {SW{1'b0}};
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_STABLE: begin
          if (!src_ok_s) begin
            state_d = ST_WAIT;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_d    = ST_REL;
            stage_d    = GW'(1);
            step_cnt_d = {PW{1'b0}};
          end else begin
            stable_cnt_d = stable_cnt_q + SW'(1);
          end
        end
        ST_REL: begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = {PW{1'b0}};
            if (stage_q == STAGE_END) begin
              state_d = ST_RUN;
            end else begin
              stage_d = stage_q + GW'(1);
            end
          end else begin
            step_cnt_d = step_cnt_q + PW'(1);
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Registered output values
  always_comb begin
    rst_d     = rst_q;
    done_d    = done_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;
    if (abort_s) begin
      rst_d  = {N_OUT{1'b1}};
      done_d = 1'b0;
      if (drop_s && (fault_q != FAULT_MAX)) begin
        fault_d = fault_q + FAULT_W'(1);
      end else begin
        fault_d = fault_q;
      end
    end else if (rel_start_s) begin
      rst_d[0] = 1'b0;
    end else if (step_hit_s) begin
      if (stage_q == STAGE_END) begin
        done_d = 1'b1;
      end else begin
        for (int k = 0; k < N_OUT; k++) begin
          rst_d[k] = rst_q[k] & (stage_q != GW'(k));
        end
      end
    end else begin
      rst_d = rst_q;
    end
    if (rel_start_s) begin
      timeout_d = 1'b0;
    end else if (tmo_hit_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  assign rst_o       = rst_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign fault_cnt_o = fault_q;
  assign state_o     = state_q;

endmodule
